dnn_sdram_arbiter: RTL and testbench
====================================

Name: dnn_sdram_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter that shares the SDRAM controller between the DNN accelerator's memory master (m0) and the VGA frame-fetch master (m1). It uses round-robin grant with pipelined reads and an in-order tag FIFO that routes each readdatavalid beat back to the master that issued the read. It sits inside dnn_accel_system, between both masters and the SDRAM controller slave port.

Parameters:
ADDR_W, 32, byte-address width on all ports
DATA_W, 32, data width; byteenable width is DATA_W/8
MAX_PENDING, 8, maximum outstanding reads (tag FIFO depth, power of 2, ≥2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_address  in  ADDR_W  master 0 address
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_writedata  in  DATA_W  master 0 write data
m0_byteenable  in  DATA_W/8  master 0 byte enables
m0_waitrequest  out  1  master 0 stall
m0_readdata  out  DATA_W  master 0 read data
m0_readdatavalid  out  1  master 0 read data valid
m1_*  (same nine signals as m0_*)  master 1
s_address  out  ADDR_W  to SDRAM controller
s_read  out  1  slave read
s_write  out  1  slave write
s_writedata  out  DATA_W  slave write data
s_byteenable  out  DATA_W/8  slave byte enables
s_waitrequest  in  1  slave stall
s_readdata  in  DATA_W  slave read data
s_readdatavalid  in  1  slave read data valid
pending  out  $clog2(MAX_PENDING)+1  outstanding read count
err_unexpected  out  1  sticky: readdatavalid received with tag FIFO empty

Behaviour:
- Reset (async, active-high): grant pointer = m0 preferred, lock = 0, tag FIFO empty, pending = 0, err_unexpected = 0. While reset is high: s_read = s_write = 0, m0/m1_waitrequest = 1, m*_readdatavalid = 0.
- Request from mN: mN_read | mN_write. Simultaneous read & write from one master is illegal; treat it as a write.
- Eligible request: any write, or a read when pending < MAX_PENDING. The count is evaluated before this cycle's pop, so no read is issued when full even if a beat returns the same cycle.
- Grant (combinational, when unlocked):
  - With one eligible requester, that requester wins.
  - With two eligible requesters, the one indicated by the rr pointer wins.
  - The granted master's address, writedata, byteenable, read and write drive the s_* outputs. s_* outputs are 0 when no requester is granted.
- Locking: if granted and s_waitrequest = 1, set lock and hold the grant until the transfer is accepted. Avalon requires the master to hold its request stable, so no re-arbitration occurs mid-transfer.
- Accept: granted request AND s_waitrequest = 0.
  - On accept: clear lock and set rr pointer to the other master.
  - On a read accept, also push the master ID into the tag FIFO.
- mN_waitrequest: 0 only in the accept cycle for mN. It is 1 when mN is not granted, when s_waitrequest = 1, or when mN's read is ineligible (FIFO full).
- Read return:
  - s_readdata fans out to both mN_readdata unchanged.
  - On s_readdatavalid = 1 with the FIFO non-empty, pulse mN_readdatavalid for the head ID in the same cycle (zero latency) and pop.
  - With the FIFO empty, drop the beat and set err_unexpected (cleared only by reset).
- pending = push − pop count. A push and pop in the same cycle leaves it unchanged. The read and write pointers wrap modulo MAX_PENDING.
- Ordering: the slave returns data in order, so FIFO order equals return order, including across interleaved m0/m1 reads.
- Writes do not touch the FIFO and are not blocked by FIFO-full.
- Reset mid-operation discards all outstanding tags. Beats that arrive later set err_unexpected; the SoC reset also resets the SDRAM controller, so this does not occur in the system.

Test Plan:
- Single master: m0 read 0x100, slave waitrequest 0, data 0xDEADBEEF after 3 cycles -> m0_waitrequest low 1 cycle, m0_readdatavalid pulses with 0xDEADBEEF, m1_readdatavalid stays 0, pending 1→0.
- Contention: m0 and m1 write continuously, s_waitrequest = 0 -> accepts alternate m0,m1,m0,m1; after reset the first accept goes to m0.
- Lock: m1 read granted, s_waitrequest high 4 cycles while m0 also requests -> s_address stays m1's for all 4 cycles; m1 accepted on cycle 5, then m0.
- Interleaved reads: m0@0x0, m1@0x4, m0@0x8 accepted, slave returns A,B,C -> m0 gets A, m1 gets B, m0 gets C, in order.
- Full: 8 m0 reads with no returns -> pending = 8, 9th read held with waitrequest = 1 while an m1 write still passes. One return with a same-cycle new read -> read not issued that cycle, issued the next.
- Error/reset: s_readdatavalid with pending = 0 -> err_unexpected = 1 and no mN_readdatavalid. Assert reset mid-burst -> all outputs at reset values immediately, pending = 0.

Source files
------------

// File: rtl/dnn_sdram_arbiter.sv
// Two-master Avalon-MM arbiter sharing one SDRAM controller port between the DNN
// accelerator (m0) and VGA fetch (m1); round-robin grant, pipelined reads, in-order tag FIFO.
module dnn_sdram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PENDING = 8
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [ADDR_W-1:0]              m0_address,
    input  logic                           m0_read,
    input  logic                           m0_write,
    input  logic [DATA_W-1:0]              m0_writedata,
    input  logic [DATA_W/8-1:0]            m0_byteenable,
    output logic                           m0_waitrequest,
    output logic [DATA_W-1:0]              m0_readdata,
    output logic                           m0_readdatavalid,

    input  logic [ADDR_W-1:0]              m1_address,
    input  logic                           m1_read,
    input  logic                           m1_write,
    input  logic [DATA_W-1:0]              m1_writedata,
    input  logic [DATA_W/8-1:0]            m1_byteenable,
    output logic                           m1_waitrequest,
    output logic [DATA_W-1:0]              m1_readdata,
    output logic                           m1_readdatavalid,

    output logic [ADDR_W-1:0]              s_address,
    output logic                           s_read,
    output logic                           s_write,
    output logic [DATA_W-1:0]              s_writedata,
    output logic [DATA_W/8-1:0]            s_byteenable,
    input  logic                           s_waitrequest,
    input  logic [DATA_W-1:0]              s_readdata,
    input  logic                           s_readdatavalid,

    output logic [$clog2(MAX_PENDING):0]   pending,
    output logic                           err_unexpected
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lockState_t;

    lockState_t        r_state;
    logic              r_lockId;
    logic              r_rrPtr;
    logic              r_err;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_tags [MAX_PENDING];

    logic w_wr0;
    logic w_rd0;
    logic w_wr1;
    logic w_rd1;
    logic w_room;
    logic w_elig0;
    logic w_elig1;
    logic w_gnt;
    logic w_gntValid;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;

    // A simultaneous read and write from one master is treated as a write.
    assign w_wr0   = m0_write;
    assign w_rd0   = m0_read & ~m0_write;
    assign w_wr1   = m1_write;
    assign w_rd1   = m1_read & ~m1_write;

    // Room is judged on the count before this cycle's pop, so a full FIFO never issues.
    assign w_room  = (r_count < CNT_W'(MAX_PENDING));
    assign w_elig0 = w_wr0 | (w_rd0 & w_room);
    assign w_elig1 = w_wr1 | (w_rd1 & w_room);

    always_comb begin
        w_gnt      = 1'b0;
        w_gntValid = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_gnt      = r_lockId;
            w_gntValid = r_lockId ? w_elig1 : w_elig0;
        end else if (w_elig0 && w_elig1) begin
            w_gnt      = r_rrPtr;
            w_gntValid = 1'b1;
        end else if (w_elig1) begin
            w_gnt      = 1'b1;
            w_gntValid = 1'b1;
        end else if (w_elig0) begin
            w_gnt      = 1'b0;
            w_gntValid = 1'b1;
        end
        if (reset) begin
            w_gntValid = 1'b0;
        end
    end

    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        if (w_gntValid) begin
            if (w_gnt) begin
                s_address    = m1_address;
                s_read       = w_rd1;
                s_write      = w_wr1;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end else begin
                s_address    = m0_address;
                s_read       = w_rd0;
                s_write      = w_wr0;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
            end
        end
    end

    assign w_accept       = w_gntValid & ~s_waitrequest;
    assign m0_waitrequest = ~(w_accept & ~w_gnt);
    assign m1_waitrequest = ~(w_accept & w_gnt);

    // Return beats are routed to the master at the FIFO head with zero latency.
    assign w_push           = w_accept & s_read;
    assign w_pop            = s_readdatavalid & (r_count != '0) & ~reset;
    assign w_head           = r_tags[r_rptr];
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop & w_head;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    assign pending          = r_count;
    assign err_unexpected   = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_OPEN;
            r_lockId <= 1'b0;
            r_rrPtr  <= 1'b0;
        end else begin
            case (r_state)
                ST_OPEN: begin
                    if (w_gntValid && s_waitrequest) begin
                        r_state  <= ST_LOCKED;
                        r_lockId <= w_gnt;
                    end
                end
                ST_LOCKED: begin
                    // A master that illegally drops its request releases the lock.
                    if (w_accept || !w_gntValid) begin
                        r_state <= ST_OPEN;
                    end
                end
                default: r_state <= ST_OPEN;
            endcase
            if (w_accept) begin
                r_rrPtr <= ~w_gnt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (s_readdatavalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tags[r_wptr] <= w_gnt;
        end
    end

endmodule

// File: tb/tb_dnn_sdram_arbiter.sv
// Self-checking bench for dnn_sdram_arbiter: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a queue-based reference model.
module tb_dnn_sdram_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAXP   = 8;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address, s_address;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [3:0]        m0_byteenable, m1_byteenable, s_byteenable;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;
    logic [3:0]        pending;
    logic              err_unexpected;

    int numChecks = 0;
    int numPass   = 0;

    // reference model state
    int                mRr;
    int                mHeld;
    int                mTags[$];
    bit                mErr;
    bit                accFlag[2];
    logic [31:0]       slaveQ[$];
    bit                busy[2];

    dnn_sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .pending(pending), .err_unexpected(err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        numChecks++;
        if (act === exp) begin
            numPass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model evaluation: expected outputs for the cycle, then the state after the next edge
    bit          wrM[2], rdM[2], eligM[2], expRdv[2];
    logic [31:0] addrM[2], dataM[2];
    logic [3:0]  beM[2];
    int          g;
    bit          gv, acc, full;

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("rst_s_read", s_read, 0);
            checkOutput("rst_s_write", s_write, 0);
            checkOutput("rst_m0_wait", m0_waitrequest, 1);
            checkOutput("rst_m1_wait", m1_waitrequest, 1);
            checkOutput("rst_m0_rdv", m0_readdatavalid, 0);
            checkOutput("rst_m1_rdv", m1_readdatavalid, 0);
            checkOutput("rst_pending", pending, 0);
            checkOutput("rst_err", err_unexpected, 0);
            mRr = 0;
            mHeld = -1;
            mTags.delete();
            mErr = 1'b0;
            accFlag[0] = 1'b0;
            accFlag[1] = 1'b0;
            slaveQ.delete();
        end else begin
            wrM[0] = m0_write;  rdM[0] = m0_read & ~m0_write;
            wrM[1] = m1_write;  rdM[1] = m1_read & ~m1_write;
            addrM[0] = m0_address;  addrM[1] = m1_address;
            dataM[0] = m0_writedata; dataM[1] = m1_writedata;
            beM[0] = m0_byteenable;  beM[1] = m1_byteenable;
            full = (mTags.size() >= MAXP);
            for (int n = 0; n < 2; n++) eligM[n] = wrM[n] | (rdM[n] & !full);
            if (mHeld >= 0) begin
                g = mHeld;
                gv = eligM[mHeld];
            end else if (eligM[0] && eligM[1]) begin
                g = mRr;
                gv = 1'b1;
            end else begin
                g = eligM[1] ? 1 : 0;
                gv = eligM[0] | eligM[1];
            end
            acc = gv && !s_waitrequest;
            expRdv[0] = 1'b0;
            expRdv[1] = 1'b0;
            if (s_readdatavalid && mTags.size() > 0) expRdv[mTags[0]] = 1'b1;

            checkOutput("s_address", s_address, gv ? addrM[g] : 0);
            checkOutput("s_read", s_read, gv ? rdM[g] : 0);
            checkOutput("s_write", s_write, gv ? wrM[g] : 0);
            checkOutput("s_writedata", s_writedata, gv ? dataM[g] : 0);
            checkOutput("s_byteenable", s_byteenable, gv ? beM[g] : 0);
            checkOutput("m0_wait", m0_waitrequest, !(acc && g == 0));
            checkOutput("m1_wait", m1_waitrequest, !(acc && g == 1));
            checkOutput("m0_rdv", m0_readdatavalid, expRdv[0]);
            checkOutput("m1_rdv", m1_readdatavalid, expRdv[1]);
            checkOutput("pending", pending, mTags.size());
            checkOutput("err", err_unexpected, mErr);
            if (expRdv[0]) checkOutput("m0_rdata", m0_readdata, s_readdata);
            if (expRdv[1]) checkOutput("m1_rdata", m1_readdata, s_readdata);

            if (s_readdatavalid) begin
                if (mTags.size() > 0) void'(mTags.pop_front());
                else mErr = 1'b1;
            end
            if (acc && rdM[g]) begin
                mTags.push_back(g);
                slaveQ.push_back($urandom);
            end
            if (gv && s_waitrequest) mHeld = g;
            if (acc) begin
                mHeld = -1;
                mRr = 1 - g;
            end
            accFlag[0] = acc && (g == 0);
            accFlag[1] = acc && (g == 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveMaster(input int n, input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic applyStimulus(input logic wait_, input logic rdv, input logic [31:0] rdata);
        s_waitrequest = wait_;
        s_readdatavalid = rdv;
        s_readdata = rdata;
    endtask

    task automatic doReset();
        tick();
        reset = 1'b1;
        driveMaster(0, 0, 0, 0, 0, 0);
        driveMaster(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0);
        busy[0] = 1'b0;
        busy[1] = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic randomCycle(input bit allowNew, input bit allowStall);
        for (int n = 0; n < 2; n++) begin
            if (accFlag[n]) busy[n] = 1'b0;
            if (!busy[n]) begin
                if (allowNew && ($urandom_range(0, 99) < 40)) begin
                    int kind;
                    kind = $urandom_range(0, 7);
                    driveMaster(n, kind < 4 || kind == 7, kind >= 4,
                                {$urandom_range(0, 4095), 2'b00}, $urandom, 4'($urandom));
                    busy[n] = 1'b1;
                end else begin
                    driveMaster(n, 0, 0, 0, 0, 0);
                end
            end
        end
        if (slaveQ.size() > 0 && ($urandom_range(0, 2) == 0 || !allowNew))
            applyStimulus(allowStall && ($urandom_range(0, 3) == 0), 1, slaveQ.pop_front());
        else
            applyStimulus(allowStall && ($urandom_range(0, 3) == 0), 0, $urandom);
        tick();
    endtask

    initial begin
        int drainCycles;
        logic [31:0] vals[3];
        int owner[3];
        reset = 1'b1;
        driveMaster(0, 0, 0, 0, 0, 0);
        driveMaster(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0);
        busy[0] = 1'b0;
        busy[1] = 1'b0;
        #1;
        checkOutput("init_m0_wait", m0_waitrequest, 1);
        checkOutput("init_pending", pending, 0);

        // single master read
        doReset();
        driveMaster(0, 1, 0, 32'h100, 0, 4'hF);
        #1;
        checkOutput("single_wait", m0_waitrequest, 0);
        checkOutput("single_addr", s_address, 32'h100);
        tick();
        driveMaster(0, 0, 0, 0, 0, 0);
        checkOutput("single_pend1", pending, 1);
        tick();
        tick();
        applyStimulus(0, 1, 32'hDEADBEEF);
        #1;
        checkOutput("single_rdv", m0_readdatavalid, 1);
        checkOutput("single_data", m0_readdata, 32'hDEADBEEF);
        checkOutput("single_m1rdv", m1_readdatavalid, 0);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("single_pend0", pending, 0);

        // contention: both write, alternation starting at m0
        doReset();
        driveMaster(0, 0, 1, 32'hA0, 32'h1111, 4'hF);
        driveMaster(1, 0, 1, 32'hB0, 32'h2222, 4'h3);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("rr_addr", s_address, (k % 2 == 0) ? 32'hA0 : 32'hB0);
            tick();
        end
        driveMaster(0, 0, 0, 0, 0, 0);
        driveMaster(1, 0, 0, 0, 0, 0);

        // lock: m1 stalled 4 cycles while m0 waits
        driveMaster(1, 1, 0, 32'h400, 0, 4'hF);
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("lock_addr0", s_address, 32'h400);
        tick();
        driveMaster(0, 0, 1, 32'h300, 32'h5555, 4'hF);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("lock_addr", s_address, 32'h400);
            checkOutput("lock_m0wait", m0_waitrequest, 1);
            tick();
        end
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("lock_m1acc", m1_waitrequest, 0);
        tick();
        driveMaster(1, 0, 0, 0, 0, 0);
        #1;
        checkOutput("lock_m0next", s_address, 32'h300);
        checkOutput("lock_m0acc", m0_waitrequest, 0);
        tick();
        driveMaster(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h11111111);
        #1;
        checkOutput("lock_m1rdv", m1_readdatavalid, 1);
        tick();
        applyStimulus(0, 0, 0);

        // interleaved reads return in order to the issuing master
        doReset();
        driveMaster(0, 1, 0, 32'h0, 0, 4'hF);
        tick();
        driveMaster(0, 0, 0, 0, 0, 0);
        driveMaster(1, 1, 0, 32'h4, 0, 4'hF);
        tick();
        driveMaster(1, 0, 0, 0, 0, 0);
        driveMaster(0, 1, 0, 32'h8, 0, 4'hF);
        tick();
        driveMaster(0, 0, 0, 0, 0, 0);
        checkOutput("il_pend", pending, 3);
        vals[0] = 32'hAAAA0000; vals[1] = 32'hBBBB0000; vals[2] = 32'hCCCC0000;
        owner[0] = 0; owner[1] = 1; owner[2] = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, vals[k]);
            #1;
            checkOutput("il_m0rdv", m0_readdatavalid, owner[k] == 0);
            checkOutput("il_m1rdv", m1_readdatavalid, owner[k] == 1);
            tick();
        end
        applyStimulus(0, 0, 0);

        // full FIFO: reads blocked, writes pass, no issue in the pop cycle
        doReset();
        driveMaster(0, 1, 0, 32'h200, 0, 4'hF);
        repeat (8) tick();
        checkOutput("full_pend", pending, 8);
        driveMaster(1, 0, 1, 32'h500, 32'h7777, 4'hF);
        #1;
        checkOutput("full_m0wait", m0_waitrequest, 1);
        checkOutput("full_m1wr", m1_waitrequest, 0);
        tick();
        driveMaster(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h12345678);
        #1;
        checkOutput("full_popcyc_wait", m0_waitrequest, 1);
        checkOutput("full_popcyc_rdv", m0_readdatavalid, 1);
        tick();
        applyStimulus(0, 0, 0);
        #1;
        checkOutput("full_after_pend", pending, 7);
        checkOutput("full_after_wait", m0_waitrequest, 0);
        tick();
        driveMaster(0, 0, 0, 0, 0, 0);
        checkOutput("full_refill", pending, 8);
        repeat (8) begin
            applyStimulus(0, 1, $urandom);
            tick();
        end
        applyStimulus(0, 0, 0);
        checkOutput("full_drained", pending, 0);

        // unexpected beat
        doReset();
        applyStimulus(0, 1, 32'hBAD);
        #1;
        checkOutput("err_m0rdv", m0_readdatavalid, 0);
        checkOutput("err_m1rdv", m1_readdatavalid, 0);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("err_set", err_unexpected, 1);
        tick();
        checkOutput("err_sticky", err_unexpected, 1);

        // reset in the middle of a read burst
        doReset();
        driveMaster(0, 1, 0, 32'h600, 0, 4'hF);
        repeat (3) tick();
        checkOutput("mid_pend", pending, 3);
        reset = 1'b1;
        #1;
        checkOutput("mid_s_read", s_read, 0);
        checkOutput("mid_m0wait", m0_waitrequest, 1);
        checkOutput("mid_pend0", pending, 0);
        tick();
        tick();
        reset = 1'b0;
        driveMaster(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h600D);
        #1;
        checkOutput("mid_late_rdv", m0_readdatavalid, 0);
        tick();
        applyStimulus(0, 0, 0);
        checkOutput("mid_late_err", err_unexpected, 1);

        // randomized traffic against the model
        doReset();
        for (int c = 0; c < 3000; c++) randomCycle(1, 1);
        drainCycles = 0;
        while ((busy[0] || busy[1] || slaveQ.size() > 0 || mTags.size() > 0) && drainCycles < 300) begin
            randomCycle(0, 0);
            drainCycles++;
        end
        checkOutput("drain_timeout", drainCycles >= 300, 0);
        checkOutput("final_pend", pending, 0);
        checkOutput("final_err", err_unexpected, 0);

        $display("%0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule
